imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit instruction
// words and writes them to instruction memory from BASE_ADDR upward while
// holding the processor. A zero word terminates the load and releases the
// processor. Reaching MAX_WORDS without a terminator flags an error.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [12:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_reg;
  logic        last_word;

  // The word being written is the one that would bring the count to MAX_WORDS
  assign last_word = ((32'(word_count) + 32'd1) == 32'(MAX_WORDS));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (byte_cnt == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_data == 32'h0) begin
          state_next = DONE;
        end else if (last_word) begin
          state_next = ERROR;
        end else begin
          state_next = LOAD;
        end
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = LOAD;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte assembly, write word/address registers and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      asm_reg    <= '0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      word_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            byte_cnt   <= '0;
            asm_reg    <= '0;
            wr_addr    <= BASE_ADDR;
            word_count <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            asm_reg  <= {asm_reg[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            // Latch the full word on the 4th byte so wr_data is stable in WRITE
            // and holds afterwards while the next word assembles in asm_reg.
            if (byte_cnt == 2'd3) wr_data <= {asm_reg[23:0], in_data};
          end
        end
        WRITE: begin
          wr_addr    <= wr_addr + 32'd4;
          word_count <= word_count + 13'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected memory writes filled by a
// word-level reference model, drained by an independent write monitor.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h00400000;
  localparam int unsigned MAXW = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [12:0] word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks;
  int          failures;
  logic [31:0] prog[4];
  int          mon_cnt;
  bit          mon_pend;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: expects exactly one wr_en cycle right after every 4th accepted
  // byte, and pops the scoreboard on each write.
  always @(negedge clk) begin
    if (wr_en || mon_pend) check32("wr_en_timing", {31'b0, wr_en}, {31'b0, mon_pend});
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h@%h required=none", wr_data, wr_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check32("wr_addr", wr_addr, e.addr);
        check32("wr_data", wr_data, e.data);
      end
    end
    if (reset) begin
      mon_cnt  = 0;
      mon_pend = 1'b0;
    end else if (in_valid && in_ready) begin
      if (mon_cnt == 3) begin
        mon_cnt  = 0;
        mon_pend = 1'b1;
      end else begin
        mon_cnt++;
        mon_pend = 1'b0;
      end
    end else begin
      mon_pend = 1'b0;
    end
  end

  task automatic check_reset_state();
    check32("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check32("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check32("rst_wr_addr", wr_addr, BASE);
    check32("rst_wr_data", wr_data, 32'd0);
    check32("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check32("rst_done", {31'b0, done}, 32'd0);
    check32("rst_error", {31'b0, error}, 32'd0);
    check32("rst_word_count", {19'b0, word_count}, 32'd0);
  endtask

  // One reset cycle; in_valid is left as the caller had it during reset
  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    check_reset_state();
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Present a byte until the loader is ready; it transfers on the next edge
  task automatic send_byte(input logic [7:0] b, input logic st);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_data  = b;
      start    = st;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check32("start_done", {31'b0, done}, 32'd0);
    check32("start_error", {31'b0, error}, 32'd0);
    check32("start_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check32("start_wr_addr", wr_addr, BASE);
    check32("start_word_count", {19'b0, word_count}, 32'd0);
  endtask

  // Hold in_valid high while the loader is not in LOAD; nothing may move
  task automatic hold_valid_idle(input logic [12:0] wc);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      check32("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check32("hold_wr_en", {31'b0, wr_en}, 32'd0);
    end
    idle();
    check32("hold_word_count", {19'b0, word_count}, {19'b0, wc});
  endtask

  // Word-level model: words are written in order from BASE until the first
  // zero word (done) or until MAXW words have been written (error).
  // mode: 0 back-to-back, 1 in_valid low every other cycle, 2 random gaps.
  task automatic do_load(input int mode, input int start_at);
    int  n;
    bit  exp_done;
    int  bi;
    bit  ok;
    n        = 0;
    exp_done = 1'b0;
    for (int i = 0; i < int'(MAXW); i++) begin
      wr_t e;
      e.addr = BASE + 32'(4 * i);
      e.data = prog[i];
      exp_q.push_back(e);
      n++;
      if (prog[i] == 32'h0) begin
        exp_done = 1'b1;
        break;
      end
    end
    bi = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        logic [31:0] w;
        w = prog[i];
        if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) idle();
        send_byte(w[8*j +: 8], (bi == start_at) ? 1'b1 : 1'b0);
        bi++;
      end
    end
    idle();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done || error) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL load_end_timeout actual=none required=done_or_error");
    end
    check32("end_done", {31'b0, done}, {31'b0, exp_done});
    check32("end_error", {31'b0, error}, {31'b0, !exp_done});
    check32("end_cpu_hold", {31'b0, cpu_hold}, {31'b0, !exp_done});
    check32("end_word_count", {19'b0, word_count}, 32'(n));
    check32("end_wr_addr", wr_addr, BASE + 32'(4 * n));
    check32("end_in_ready", {31'b0, in_ready}, 32'd0);
    check32("end_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    mon_cnt  = 0;
    mon_pend = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    apply_reset();

    // Stream offered while idle is not consumed
    hold_valid_idle(13'd0);

    // Two-word program with terminator, back-to-back bytes
    pulse_start();
    prog = '{32'h20080005, 32'h0, 32'h0, 32'h0};
    do_load(0, -1);
    check32("r33_wr_data_hold", wr_data, 32'h0);

    // Stream offered in DONE is not consumed
    hold_valid_idle(13'd2);

    // Reload from DONE, in_valid toggling every other cycle
    pulse_start();
    prog = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    do_load(1, -1);

    // MAX_WORDS nonzero words -> error
    pulse_start();
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_load(0, -1);

    // start pulsed mid-word in LOAD is ignored (restart from ERROR first)
    pulse_start();
    prog = '{32'hA1B2C3D4, 32'h01020304, 32'hFFFFFFFF, 32'h0};
    do_load(0, 6);

    // Reset after two bytes of a word: nothing written, reset values restored
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    apply_reset();
    repeat (3) idle();
    check_reset_state();

    // Randomized programs and byte pacing
    for (int it = 0; it < 25; it++) begin
      pulse_start();
      for (int i = 0; i < int'(MAXW); i++) begin
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(99) < 35) v = 32'h0;
        else if (v == 32'h0) v = 32'h1;
        prog[i] = v;
      end
      do_load(int'($urandom_range(2)), -1);
    end

    repeat (3) idle();
    check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
